ahb_gpio: RTL and testbench

AHB-Lite GPIO peripheral inside `cm3_min_soc`, directly upstream of the FPGA pad logic. It drives `GPIO_O` and `GPIO_OE` into the top-level tristate buffers and consumes the raw `GPIO_I` pad samples. It synchronises the inputs, exposes them to the CM3 over AHB, and raises a level interrupt on selected input edges.

---
 rtl/gpio_pkg.sv | 25 ++
 rtl/gpio_sync.sv | 35 +++
 rtl/ahb_gpio.sv | 137 +++++++++++++
 tb/tb_ahb_gpio.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared register-offset constants for the AHB GPIO peripheral.
// Offsets are 3-bit word indices taken from HADDR[4:2].
package gpio_pkg;

    localparam logic [2:0] GPIO_DOUT = 3'd0;
    localparam logic [2:0] GPIO_DIN  = 3'd1;
    localparam logic [2:0] GPIO_OE   = 3'd2;
    localparam logic [2:0] GPIO_SET  = 3'd3;
    localparam logic [2:0] GPIO_CLR  = 3'd4;
    localparam logic [2:0] GPIO_IE   = 3'd5;
    localparam logic [2:0] GPIO_POL  = 3'd6;
    localparam logic [2:0] GPIO_IS   = 3'd7;

    typedef enum logic [2:0] {
        REG_DOUT = GPIO_DOUT,
        REG_DIN  = GPIO_DIN,
        REG_OE   = GPIO_OE,
        REG_SET  = GPIO_SET,
        REG_CLR  = GPIO_CLR,
        REG_IE   = GPIO_IE,
        REG_POL  = GPIO_POL,
        REG_IS   = GPIO_IS
    } gpio_reg_e;

endpackage

// File: rtl/gpio_sync.sv
// Pad input conditioning: two-flop synchroniser, history flop and
// per-bit rise/fall detection on the synchronised value.
module gpio_sync #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             PORESETn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] prev_q;

    // Synchroniser chain plus one cycle of history for edge detection
    always_ff @(posedge CLK) begin
        if (!PORESETn) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign q    = s2_q;
    assign rise = s2_q & ~prev_q;
    assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/ahb_gpio.sv
// AHB-Lite GPIO slave: zero-wait-state register file driving the pad
// output/enable lines, synchronised inputs and an edge interrupt.
module ahb_gpio #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             PORESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [2:0]       HSIZE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    output logic             HRESP,
    input  logic [WIDTH-1:0] GPIO_I,
    output logic [WIDTH-1:0] GPIO_O,
    output logic [WIDTH-1:0] GPIO_OE,
    output logic             IRQ
);
    import gpio_pkg::*;

    logic             wr_en_q;
    logic             rd_en_q;
    gpio_reg_e        addr_q;
    logic             accept_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] din_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] ie_q, ie_d;
    logic [WIDTH-1:0] pol_q, pol_d;
    logic [WIDTH-1:0] is_q, is_d;
    logic [31:0]      rdata_s;
    logic             unused_s;

    assign accept_s = HSEL & HTRANS[1] & HREADY;
    assign wdata_s  = HWDATA[WIDTH-1:0];
    assign unused_s = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

    gpio_sync #(.WIDTH(WIDTH)) u_sync (
        .CLK      (CLK),
        .PORESETn (PORESETn),
        .d        (GPIO_I),
        .q        (din_s),
        .rise     (rise_s),
        .fall     (fall_s)
    );

    assign edge_s = (pol_q & rise_s) | (~pol_q & fall_s);

    // Address-phase capture; a reset here drops any pending data phase
    always_ff @(posedge CLK) begin
        if (!PORESETn) begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= REG_DOUT;
        end else begin
            wr_en_q <= accept_s & HWRITE;
            rd_en_q <= accept_s & ~HWRITE;
            addr_q  <= accept_s ? gpio_reg_e'(HADDR[4:2]) : REG_DOUT;
        end
    end

    // Data-phase register update; IS set from edges overrides W1C
    always_comb begin
        dout_d = dout_q;
        oe_d   = oe_q;
        ie_d   = ie_q;
        pol_d  = pol_q;
        clr_s  = '0;
        if (wr_en_q) begin
            case (addr_q)
                REG_DOUT: dout_d = wdata_s;
                REG_OE:   oe_d   = wdata_s;
                REG_SET:  dout_d = dout_q | wdata_s;
                REG_CLR:  dout_d = dout_q & ~wdata_s;
                REG_IE:   ie_d   = wdata_s;
                REG_POL:  pol_d  = wdata_s;
                REG_IS:   clr_s  = wdata_s;
                default:  clr_s  = '0;
            endcase
        end else begin
            clr_s = '0;
        end
        is_d = (is_q & ~clr_s) | edge_s;
    end

    // Register file state
    always_ff @(posedge CLK) begin
        if (!PORESETn) begin
            dout_q <= '0;
            oe_q   <= '0;
            ie_q   <= '0;
            pol_q  <= '0;
            is_q   <= '0;
        end else begin
            dout_q <= dout_d;
            oe_q   <= oe_d;
            ie_q   <= ie_d;
            pol_q  <= pol_d;
            is_q   <= is_d;
        end
    end

    // Read mux driven from the registered address so reads see same-cycle writes' results
    always_comb begin
        rdata_s = '0;
        if (rd_en_q) begin
            case (addr_q)
                REG_DOUT: rdata_s[WIDTH-1:0] = dout_q;
                REG_DIN:  rdata_s[WIDTH-1:0] = din_s;
                REG_OE:   rdata_s[WIDTH-1:0] = oe_q;
                REG_IE:   rdata_s[WIDTH-1:0] = ie_q;
                REG_POL:  rdata_s[WIDTH-1:0] = pol_q;
                REG_IS:   rdata_s[WIDTH-1:0] = is_q;
                default:  rdata_s = '0;
            endcase
        end else begin
            rdata_s = '0;
        end
    end

    assign HRDATA    = rdata_s;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign GPIO_O    = dout_q;
    assign GPIO_OE   = oe_q;
    assign IRQ       = |(is_q & ie_q);

endmodule

// File: tb/tb_ahb_gpio.sv
// Directed and randomised checks of ahb_gpio against a register-level
// reference model held in the bench.
module tb_ahb_gpio;

    localparam int W = 8;
    localparam logic [31:0] MASK = 32'h0000_00FF;

    logic          CLK = 1'b0;
    logic          PORESETn;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [W-1:0]  GPIO_I;
    logic [W-1:0]  GPIO_O;
    logic [W-1:0]  GPIO_OE;
    logic          IRQ;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_dout, m_oe, m_ie, m_pol, m_is, m_in;

    ahb_gpio #(.WIDTH(W)) dut (
        .CLK(CLK), .PORESETn(PORESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .GPIO_I(GPIO_I), .GPIO_O(GPIO_O), .GPIO_OE(GPIO_OE), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = 32'h0;
    endtask

    task automatic addr_phase(input logic [2:0] off, input logic wr);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HADDR  = {27'h4000_000, off, 2'b00};
    endtask

    task automatic ahb_write(input logic [2:0] off, input logic [31:0] d);
        addr_phase(off, 1'b1);
        tick();
        bus_idle();
        HWDATA = d;
        tick();
    endtask

    task automatic ahb_read(input logic [2:0] off, output logic [31:0] d);
        addr_phase(off, 1'b0);
        tick();
        bus_idle();
        d = HRDATA;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd0:    return m_dout;
            3'd1:    return m_in;
            3'd2:    return m_oe;
            3'd5:    return m_ie;
            3'd6:    return m_pol;
            3'd7:    return m_is;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [2:0] off, input logic [31:0] d);
        case (off)
            3'd0:    m_dout = d & MASK;
            3'd2:    m_oe   = d & MASK;
            3'd3:    m_dout = m_dout | (d & MASK);
            3'd4:    m_dout = m_dout & ~d;
            3'd5:    m_ie   = d & MASK;
            3'd6:    m_pol  = d & MASK;
            3'd7:    m_is   = m_is & ~d;
            default: ;
        endcase
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] nv;
        logic [2:0]  off;

        PORESETn = 1'b0;
        HSIZE    = 3'b010;
        HREADY   = 1'b1;
        HWDATA   = 32'h0;
        GPIO_I   = '0;
        bus_idle();

        // reset state
        tick(); tick();
        check("rst_oe",   {24'h0, GPIO_OE}, 32'h0);
        check("rst_o",    {24'h0, GPIO_O},  32'h0);
        check("rst_irq",  {31'h0, IRQ},     32'h0);
        check("rst_rdy",  {31'h0, HREADYOUT}, 32'h1);
        check("rst_resp", {31'h0, HRESP},   32'h0);
        PORESETn = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            ahb_read(3'(i), rd);
            check($sformatf("rst_rd%0d", i), rd, 32'h0);
        end

        // output data/enable, with back-to-back write then read of DOUT
        ahb_write(3'd2, 32'h0000_000F);
        addr_phase(3'd0, 1'b1);
        tick();
        HWDATA = 32'h1234_56A5;
        addr_phase(3'd0, 1'b0);
        tick();
        bus_idle();
        check("b2b_rd", HRDATA, 32'h0000_00A5);
        check("gpio_o",  {24'h0, GPIO_O},  32'hA5);
        check("gpio_oe", {24'h0, GPIO_OE}, 32'h0F);

        // SET / CLR
        ahb_write(3'd0, 32'hF0);
        ahb_write(3'd3, 32'h03);
        ahb_read(3'd0, rd);
        check("set_dout", rd, 32'hF3);
        ahb_write(3'd4, 32'h30);
        ahb_read(3'd0, rd);
        check("clr_dout", rd, 32'hC3);
        check("clr_pin", {24'h0, GPIO_O}, 32'hC3);
        ahb_read(3'd3, rd);
        check("set_rd0", rd, 32'h0);
        ahb_read(3'd4, rd);
        check("clr_rd0", rd, 32'h0);

        // rising edge on bit 0: DIN latency and IRQ latency
        ahb_write(3'd6, 32'h01);
        ahb_write(3'd5, 32'h01);
        GPIO_I[0] = 1'b1;
        ahb_read(3'd1, rd);
        check("din_k", rd, 32'h0);
        ahb_read(3'd1, rd);
        check("din_k1", rd, 32'h1);
        check("irq_k1", {31'h0, IRQ}, 32'h0);
        tick();
        check("irq_k2", {31'h0, IRQ}, 32'h1);
        ahb_read(3'd7, rd);
        check("is_rise", rd, 32'h01);

        // clear, then a falling edge must not set status with POL=1
        ahb_write(3'd7, 32'h01);
        check("irq_clr", {31'h0, IRQ}, 32'h0);
        GPIO_I[0] = 1'b0;
        repeat (4) tick();
        check("irq_fall", {31'h0, IRQ}, 32'h0);
        ahb_read(3'd7, rd);
        check("is_fall", rd, 32'h0);

        // set wins over coincident W1C
        GPIO_I[0] = 1'b1;
        repeat (4) tick();
        GPIO_I[0] = 1'b0;
        repeat (4) tick();
        ahb_read(3'd7, rd);
        check("is_pre", rd, 32'h01);
        GPIO_I[0] = 1'b1;
        tick();
        ahb_write(3'd7, 32'h01);
        check("irq_setwin", {31'h0, IRQ}, 32'h1);
        ahb_read(3'd7, rd);
        check("is_setwin", rd, 32'h01);
        ahb_write(3'd7, 32'h01);
        check("irq_w1c", {31'h0, IRQ}, 32'h0);
        ahb_read(3'd7, rd);
        check("is_w1c", rd, 32'h0);

        // reset during the data phase of a DOUT write
        GPIO_I = '0;
        repeat (4) tick();
        addr_phase(3'd0, 1'b1);
        tick();
        bus_idle();
        HWDATA   = 32'hFF;
        PORESETn = 1'b0;
        tick();
        check("rstdp_rdy",  {31'h0, HREADYOUT}, 32'h1);
        check("rstdp_resp", {31'h0, HRESP},     32'h0);
        PORESETn = 1'b1;
        tick();
        check("rstdp_pin", {24'h0, GPIO_O}, 32'h0);
        ahb_read(3'd0, rd);
        check("rstdp_dout", rd, 32'h0);

        // randomised operations against the register-level model
        m_dout = 0; m_oe = 0; m_ie = 0; m_pol = 0; m_is = 0; m_in = 0;
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(2, 0))
                0: begin
                    off = 3'($urandom_range(7, 0));
                    nv  = $urandom;
                    ahb_write(off, nv);
                    model_write(off, nv);
                end
                1: begin
                    off = 3'($urandom_range(7, 0));
                    ahb_read(off, rd);
                    check($sformatf("rnd_rd%0d", off), rd, model_read(off));
                end
                default: begin
                    nv = $urandom & MASK;
                    m_is = m_is | (m_pol & nv & ~m_in) | (~m_pol & ~nv & m_in & MASK);
                    m_in = nv;
                    GPIO_I = nv[W-1:0];
                    repeat (4) tick();
                end
            endcase
            check("rnd_o",   {24'h0, GPIO_O},  m_dout);
            check("rnd_oe",  {24'h0, GPIO_OE}, m_oe);
            check("rnd_irq", {31'h0, IRQ},     {31'h0, |(m_is & m_ie)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
